// File: rtl/me_ctrl_pkg.sv
// Shared definitions for the motion-estimator input-conditioning slice:
// offset widths, key FSM states and the counter sizing helper.
package me_ctrl_pkg;

  localparam int SHIFT_R_W = 8;
  localparam int SHIFT_S_W = 10;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } key_state_e;

  // Width needed for a counter that can hold 0..value.
  function automatic int cnt_width(input int unsigned value);
    return (value == 0) ? 1 : $clog2(value + 1);
  endfunction

endpackage

// File: rtl/me_input_ctrl_debounce_sync.sv
// Two-flop synchronizer followed by a debouncer: the output follows the
// synced input only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_sync
  import me_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any agreeing sample restarts the count; the Nth disagreeing one flips.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sync flops reset to the idle level so no phantom edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      db_q    <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/me_input_ctrl.sv
// Input conditioning for the motion estimator: debounced start/select levels,
// per-key step/auto-repeat pulses and the shiftR/shiftS ROM address offsets.
module me_input_ctrl
  import me_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                 CYCLONEV_CLK_50,
  input  logic                 RESET_N,
  input  logic [9:0]           SW,
  input  logic [1:0]           KEY,
  output logic                 start,
  output logic                 sel_s,
  output logic [SHIFT_R_W-1:0] shiftR,
  output logic [SHIFT_S_W-1:0] shiftS,
  output logic [1:0]           key_pulse
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = cnt_width(TMAX);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [1:0] key_db;
  logic [1:0] pressed;
  logic       start_db;
  logic       sel_db;
  logic       unused_sw;

  assign unused_sw = ^SW[8:1];

  for (genvar g = 0; g < 2; g++) begin : g_key_db
    debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_db_key (
      .clk  (CYCLONEV_CLK_50),
      .rst_n(RESET_N),
      .din  (KEY[g]),
      .dout (key_db[g])
    );
  end

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b0)
  ) u_db_sel (
    .clk  (CYCLONEV_CLK_50),
    .rst_n(RESET_N),
    .din  (SW[0]),
    .dout (sel_db)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b0)
  ) u_db_start (
    .clk  (CYCLONEV_CLK_50),
    .rst_n(RESET_N),
    .din  (SW[9]),
    .dout (start_db)
  );

  assign pressed = ~key_db;

  key_state_e            state_q [2];
  key_state_e            state_d [2];
  logic [TW-1:0]         timer_q [2];
  logic [TW-1:0]         timer_d [2];
  logic [1:0]            key_pulse_q, key_pulse_d;
  logic [SHIFT_R_W-1:0]  shift_r_q, shift_r_d;
  logic [SHIFT_S_W-1:0]  shift_s_q, shift_s_d;

  // Timers compare against N-1 so the pulse register rises exactly N cycles apart.
  always_comb begin
    key_pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        RELEASED: begin
          if (pressed[i]) begin
            key_pulse_d[i] = 1'b1;
            timer_d[i]     = '0;
            state_d[i]     = HELD_DELAY;
          end
        end
        HELD_DELAY: begin
          if (!pressed[i]) begin
            timer_d[i] = '0;
            state_d[i] = RELEASED;
          end else if (timer_q[i] == DELAY_LAST) begin
            key_pulse_d[i] = 1'b1;
            timer_d[i]     = '0;
            state_d[i]     = HELD_REPEAT;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        HELD_REPEAT: begin
          if (!pressed[i]) begin
            timer_d[i] = '0;
            state_d[i] = RELEASED;
          end else if (timer_q[i] == PERIOD_LAST) begin
            key_pulse_d[i] = 1'b1;
            timer_d[i]     = '0;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        default: begin
          timer_d[i] = '0;
          state_d[i] = RELEASED;
        end
      endcase
    end
  end

  // Offsets wrap modulo their width; both keys at once cancel out.
  always_comb begin
    shift_r_d = shift_r_q;
    shift_s_d = shift_s_q;
    if (!start_db) begin
      case (key_pulse_q)
        2'b01: begin
          if (sel_db) shift_s_d = shift_s_q + 1'b1;
          else        shift_r_d = shift_r_q + 1'b1;
        end
        2'b10: begin
          if (sel_db) shift_s_d = shift_s_q - 1'b1;
          else        shift_r_d = shift_r_q - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CYCLONEV_CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= RELEASED;
        timer_q[i] <= '0;
      end
      key_pulse_q <= '0;
      shift_r_q   <= '0;
      shift_s_q   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      key_pulse_q <= key_pulse_d;
      shift_r_q   <= shift_r_d;
      shift_s_q   <= shift_s_d;
    end
  end

  assign start     = start_db;
  assign sel_s     = sel_db;
  assign shiftR    = shift_r_q;
  assign shiftS    = shift_s_q;
  assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_me_input_ctrl.sv
// Randomized bench for me_input_ctrl against a behavioural model built from
// sample windows, hold-time arithmetic and modular offset math.
module tb_me_input_ctrl;

  localparam int N  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam logic [N-1:0] ONES = '1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw;
  logic [1:0] key;
  logic       start, sel_s;
  logic [7:0] shift_r;
  logic [9:0] shift_s;
  logic [1:0] key_pulse;

  me_input_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CYCLONEV_CLK_50(clk),
    .RESET_N        (rst_n),
    .SW             (sw),
    .KEY            (key),
    .start          (start),
    .sel_s          (sel_s),
    .shiftR         (shift_r),
    .shiftS         (shift_s),
    .key_pulse      (key_pulse)
  );

  always #5 clk = ~clk;

  int vec_count  = 0;
  int miss_count = 0;

  // Raw input order: 0 KEY[0], 1 KEY[1], 2 SW[0], 3 SW[9].
  logic [3:0]   raw;
  int           hold_left [4];
  logic [3:0]   m_s1, m_s2, m_db;
  logic [N-1:0] win [4];
  int           hc [2];
  logic [1:0]   m_pulse;
  int           m_r, m_s;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vec_count++;
    if (obs != exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void driveRaw();
    key = raw[1:0];
    sw  = {raw[3], 8'($urandom), raw[2]};
  endfunction

  function automatic void modelReset();
    m_s1 = 4'b0011;
    m_s2 = 4'b0011;
    m_db = 4'b0011;
    for (int i = 0; i < 4; i++) win[i] = m_db[i] ? ONES : '0;
    hc[0]   = -1;
    hc[1]   = -1;
    m_pulse = 2'b00;
    m_r     = 0;
    m_s     = 0;
  endfunction

  // One clock edge of the reference, reading every pre-edge value first.
  function automatic void modelEdge();
    logic [1:0] np;
    if (!m_db[3]) begin
      if (m_pulse == 2'b01) begin
        if (m_db[2]) m_s = (m_s + 1) % 1024;
        else         m_r = (m_r + 1) % 256;
      end else if (m_pulse == 2'b10) begin
        if (m_db[2]) m_s = (m_s + 1023) % 1024;
        else         m_r = (m_r + 255) % 256;
      end
    end
    np = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (!m_db[k]) begin
        hc[k] = (hc[k] < 0) ? 0 : hc[k] + 1;
        np[k] = (hc[k] == 0) || (hc[k] == RD) || (hc[k] > RD && (hc[k] - RD) % RP == 0);
      end else begin
        hc[k] = -1;
      end
    end
    m_pulse = np;
    for (int i = 0; i < 4; i++) begin
      win[i] = {win[i][N-2:0], m_s2[i]};
      if ((m_db[i] && win[i] == '0) || (!m_db[i] && win[i] == ONES)) m_db[i] = ~m_db[i];
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endfunction

  task automatic checkAll();
    checkOutput("start",     int'(start),     int'(m_db[3]));
    checkOutput("sel_s",     int'(sel_s),     int'(m_db[2]));
    checkOutput("shiftR",    int'(shift_r),   m_r);
    checkOutput("shiftS",    int'(shift_s),   m_s);
    checkOutput("key_pulse", int'(key_pulse), int'(m_pulse));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) modelEdge();
    checkAll();
  endtask

  // Runs cycles with the current raw levels, or with random level/glitch runs.
  task automatic applyStimulus(input int cycles, input bit rand_mode);
    for (int c = 0; c < cycles; c++) begin
      if (rand_mode) begin
        for (int i = 0; i < 4; i++) begin
          if (hold_left[i] == 0) begin
            if (i == 3) raw[i] = ($urandom_range(0, 4) == 0);
            else        raw[i] = 1'($urandom_range(0, 1));
            hold_left[i] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, N - 1)
                                                      : $urandom_range(5, 60);
          end
          hold_left[i]--;
        end
      end
      driveRaw();
      tick();
    end
  endtask

  task automatic setRaw(input logic [3:0] v, input int cycles);
    raw = v;
    applyStimulus(cycles, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) hold_left[i] = 0;
    rst_n = 1'b0;
    raw   = 4'b0011;
    driveRaw();
    modelReset();
    applyStimulus(3, 1'b0);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Decrement shiftR from 0, then wrap shiftS down and back up.
    setRaw(4'b0011, 5);
    setRaw(4'b0001, 15);
    setRaw(4'b0011, 10);
    setRaw(4'b0111, 10);
    setRaw(4'b0101, 15);
    setRaw(4'b0111, 10);
    setRaw(4'b0110, 15);
    setRaw(4'b0111, 10);
    setRaw(4'b0011, 10);

    // Bounce on KEY[1] shorter than the debounce window.
    for (int j = 0; j < 5; j++) begin
      setRaw(4'b0001, 2);
      setRaw(4'b0011, 2);
    end
    setRaw(4'b0011, 10);

    // Long hold for auto-repeat, then freeze while start is high.
    setRaw(4'b0010, 90);
    setRaw(4'b0011, 10);
    setRaw(4'b1011, 10);
    setRaw(4'b1010, 40);
    setRaw(4'b1011, 10);
    setRaw(4'b0011, 10);

    // Both keys together cancel.
    setRaw(4'b0000, 40);
    setRaw(4'b0011, 10);

    $display("[TB] random phase");
    applyStimulus(2500, 1'b1);

    // Asynchronous reset while KEY[0] auto-repeats, key still held after release.
    setRaw(4'b0010, 50);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_start",  int'(start),     0);
    checkOutput("async_sel",    int'(sel_s),     0);
    checkOutput("async_shiftR", int'(shift_r),   0);
    checkOutput("async_shiftS", int'(shift_s),   0);
    checkOutput("async_pulse",  int'(key_pulse), 0);
    modelReset();
    applyStimulus(3, 1'b0);
    rst_n = 1'b1;
    setRaw(4'b0010, 15);
    setRaw(4'b0011, 10);

    for (int i = 0; i < 4; i++) hold_left[i] = 0;
    applyStimulus(1500, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
